reg_dump_tx: RTL and testbench
==============================

Name: reg_dump_tx

Overview:
- Debug readout engine: on request, reads all 32 CPU general registers through a dedicated register-file read port and transmits them over a UART TX line.
- Frame: header byte, then each register as 4 bytes, most significant byte first.
- Sits beside the CPU core. It drives `cpu_halt` so register contents stay frozen for the whole dump.

Parameters:
- CLKS_PER_BIT, 10417, clock cycles per UART bit (100 MHz / 9600 baud).
- HEADER_BYTE, 8'hA5, first byte of every dump frame.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- dump_req  in  1  level request; accepted only in IDLE
- reg_addr  out  5  register-file read address
- reg_data  in  32  register-file read data, combinational from reg_addr
- cpu_halt  out  1  stall request to core while dump active
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse at end of dump
- tx  out  1  UART serial output, idle high

Behaviour:
- Reset values: reg_addr=0, cpu_halt=0, busy=0, done=0, tx=1, state=IDLE.
- Reset applies in any state, including mid-byte: tx=1 and busy=0 after the next clock edge; a partial frame is abandoned.
- All outputs are registered.
- UART format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles, so one byte takes 10*CLKS_PER_BIT cycles.
- Frame: HEADER_BYTE, then r0..r31 with 4 bytes each ([31:24],[23:16],[15:8],[7:0]). Total 129 bytes.
- FSM states and transitions:
  - IDLE: if dump_req=1, go to HALT. busy and cpu_halt rise at the same edge.
  - HALT: one settle cycle so the core's in-flight posedge write completes. Load HEADER_BYTE into the shifter, then go to SEND_HDR.
  - SEND_HDR: transmit the header. When its stop bit ends, set reg_addr=0 and go to FETCH.
  - FETCH: one cycle. Latch reg_data into a 32-bit word register, set byte index=3, go to SEND.
  - SEND: transmit word[8*idx+7 : 8*idx]. When its stop bit ends:
    - idx>0: decrement idx and stay in SEND.
    - idx=0 and reg_addr<31: increment reg_addr and go to FETCH.
    - idx=0 and reg_addr=31: go to FINISH.
  - FINISH: one cycle. done=1, busy=0, cpu_halt=0, reg_addr=0, return to IDLE.
- Back-to-back bytes: the next start bit begins the cycle after the previous stop bit ends. The only gaps are the one-cycle FETCH slots (tx held at 1 during them).
- dump_req is ignored while busy. If dump_req is still high in the cycle after done, a new dump starts (level semantics).
- Bit timer: counts 0..CLKS_PER_BIT-1 and must be wide enough for CLKS_PER_BIT; use $clog2. The bit counter runs 0..9.
- Total dump latency from acceptance to done = 1 (HALT) + 129*10*CLKS_PER_BIT + 32 (FETCH) + 1 (FINISH) cycles.
- reg_addr changes only in the SEND→FETCH transition, at reset, or in FINISH. It is stable for at least one cycle before sampling.

Decomposition:
- Shared defines header (existing includes/defines.v): UART_HEADER_BYTE, NUM_GPR=32, and the FSM state encodings (IDLE, HALT, SEND_HDR, FETCH, SEND, FINISH) as `define constants.
- Sub-module uart_tx_byte: byte-serializer with a load/data_in/busy/tx handshake, owning the bit timer and shifter. reg_dump_tx sequences bytes into it.

Test Plan (CLKS_PER_BIT=4 in all scenarios):
- Reset idle: hold reset 3 cycles, release -> tx=1, busy=0, cpu_halt=0, reg_addr=0, no done for 100 cycles.
- Full dump with r[i]=32'h01020300+i (r29=32'h7FFC for stack init check) and a 1-cycle dump_req:
  - UART decoder receives 129 bytes: A5, then 01 02 03 00, 01 02 03 01, ..., and for r29 00 00 7F FC.
  - done pulses once, exactly 1+5160+32+1=5194 cycles after acceptance.
  - cpu_halt is high throughout.
- Bit timing: measure the first start bit -> low for exactly 4 cycles. Header bit sequence is 0,1,0,1,0,0,1,0,1,1 (A5 LSB first, then stop).
- Ignored request: pulse dump_req again mid-dump at byte 50 -> frame unchanged, exactly one done. Hold dump_req high continuously -> a second dump starts 1 cycle after done.
- Reset mid-dump: assert reset during the 3rd bit of byte 70 -> next cycle tx=1, busy=0, cpu_halt=0. A later dump_req produces a complete, correct 129-byte frame.
- Changing registers: modify r5 via the bench between FETCH of r5 and its last byte -> transmitted r5 bytes equal the value latched at FETCH.

Source files
------------

// File: rtl/reg_dump_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_tx_pkg
// Description : Shared constants, FSM state encoding and byte-select helper
//               for the register-dump UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_dump_tx_pkg;

    // Number of CPU general-purpose registers walked by one dump.
    localparam int NUM_GPR = 32;

    // First byte of every dump frame.
    localparam logic [7:0] UART_HEADER_BYTE = 8'hA5;

    // Start bit + 8 data bits + stop bit.
    localparam int UART_BITS_PER_FRAME = 10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HALT     = 3'd1,
        ST_SEND_HDR = 3'd2,
        ST_FETCH    = 3'd3,
        ST_SEND     = 3'd4,
        ST_FINISH   = 3'd5
    } state_t;

    // Returns byte idx of a 32-bit word (idx 3 = bits [31:24]).
    function automatic logic [7:0] word_byte(input logic [31:0] word,
                                             input logic [1:0]  idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_dump_tx_uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_tx_uart_tx_byte
// Description : UART byte serializer (8N1). Owns the bit timer and the frame
//               shifter; a new byte may be loaded while idle or in the very
//               last cycle of the previous stop bit, giving gap-free streams.
// Ports       : clock, reset   - system clock, synchronous active-high reset
//               load, data_in  - accept data_in as the next byte
//               busy           - a frame is being shifted out (registered)
//               last           - final cycle of the current stop bit
//               tx             - serial output, idle high (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_tx_uart_tx_byte
    import reg_dump_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       last,
    output logic       tx
);

    localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TIMER_W-1:0] c_last_tick = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]         c_stop_bit  = 4'(UART_BITS_PER_FRAME - 1);

    logic [TIMER_W-1:0] r_timer;
    logic [3:0]         r_bit;
    // Frame bits still to be shown; bit 0 is the one currently on tx.
    logic [9:0]         r_frame;

    logic w_bit_end;

    assign w_bit_end = busy && (r_timer == c_last_tick);
    assign last      = w_bit_end && (r_bit == c_stop_bit);

    always_ff @(posedge clock) begin
        if (reset) begin
            busy    <= 1'b0;
            tx      <= 1'b1;
            r_timer <= '0;
            r_bit   <= '0;
            r_frame <= '1;
        end else if (load && (!busy || last)) begin
            // Start bit goes on the line from the next cycle.
            r_frame <= {1'b1, data_in, 1'b0};
            busy    <= 1'b1;
            r_timer <= '0;
            r_bit   <= '0;
            tx      <= 1'b0;
        end else if (busy) begin
            if (w_bit_end) begin
                r_timer <= '0;
                if (r_bit == c_stop_bit) begin
                    busy <= 1'b0;
                    tx   <= 1'b1;
                end else begin
                    r_bit   <= r_bit + 4'd1;
                    r_frame <= {1'b1, r_frame[9:1]};
                    tx      <= r_frame[1];
                end
            end else begin
                r_timer <= r_timer + TIMER_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_dump_tx.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_tx
// Description : Debug readout engine. On request it halts the core, then
//               streams a header byte followed by all 32 general registers
//               (MSB first) out of a UART TX line, and pulses done.
// Ports       : clock, reset - system clock, synchronous active-high reset
//               dump_req     - level request, sampled only when idle
//               reg_addr     - register-file read address
//               reg_data     - register-file read data (combinational)
//               cpu_halt     - holds the core frozen during the dump
//               busy         - dump in progress
//               done         - one-cycle pulse when the dump completes
//               tx           - UART serial output, idle high
// Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_tx
    import reg_dump_tx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 10417,
    parameter logic [7:0] HEADER_BYTE  = UART_HEADER_BYTE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dump_req,
    output logic [4:0]  reg_addr,
    input  logic [31:0] reg_data,
    output logic        cpu_halt,
    output logic        busy,
    output logic        done,
    output logic        tx
);

    localparam logic [4:0] c_last_gpr = 5'(NUM_GPR - 1);

    state_t      r_state;
    logic [31:0] r_word;
    logic [1:0]  r_idx;

    logic        w_load;
    logic [7:0]  w_load_data;
    logic        w_byte_busy;
    logic        w_byte_last;

    // The serializer is fed combinationally so each new byte starts the
    // cycle after the previous stop bit ends. In FETCH the top byte comes
    // straight from reg_data, which is the same value latched into r_word.
    always_comb begin
        w_load      = 1'b0;
        w_load_data = 8'h00;
        case (r_state)
            ST_HALT: begin
                w_load      = !w_byte_busy;
                w_load_data = HEADER_BYTE;
            end
            ST_FETCH: begin
                w_load      = 1'b1;
                w_load_data = reg_data[31:24];
            end
            ST_SEND: begin
                w_load      = w_byte_last && (r_idx != 2'd0);
                w_load_data = word_byte(r_word, r_idx - 2'd1);
            end
            default: begin
                w_load      = 1'b0;
                w_load_data = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            reg_addr <= '0;
            cpu_halt <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            r_word   <= '0;
            r_idx    <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (dump_req) begin
                        r_state  <= ST_HALT;
                        busy     <= 1'b1;
                        cpu_halt <= 1'b1;
                    end
                end
                ST_HALT: begin
                    // Settle cycle: any in-flight core write lands now.
                    if (!w_byte_busy) begin
                        r_state <= ST_SEND_HDR;
                    end
                end
                ST_SEND_HDR: begin
                    if (w_byte_last) begin
                        reg_addr <= '0;
                        r_state  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_word  <= reg_data;
                    r_idx   <= 2'd3;
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_byte_last) begin
                        if (r_idx != 2'd0) begin
                            r_idx <= r_idx - 2'd1;
                        end else if (reg_addr != c_last_gpr) begin
                            reg_addr <= reg_addr + 5'd1;
                            r_state  <= ST_FETCH;
                        end else begin
                            r_state <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    cpu_halt <= 1'b0;
                    reg_addr <= '0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    reg_dump_tx_uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .clock   (clock),
        .reset   (reset),
        .load    (w_load),
        .data_in (w_load_data),
        .busy    (w_byte_busy),
        .last    (w_byte_last),
        .tx      (tx)
    );

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_dump_tx
// Description : Self-checking bench for reg_dump_tx with a bench-side UART
//               receiver and a frame model built from the register array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_dump_tx;

    localparam int CPB         = 4;
    localparam int FRAME_LEN   = 129;
    localparam int DUMP_CYCLES = 1 + FRAME_LEN * 10 * CPB + 32 + 1;

    logic        clock;
    logic        reset;
    logic        dump_req;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        cpu_halt;
    logic        busy;
    logic        done;
    logic        tx;

    logic [31:0] regs [32];

    int n_checks = 0;
    int n_fail   = 0;

    // Receiver state and captured bytes
    logic       rx_flush = 1'b0;
    bit         rx_on    = 1'b0;
    int         rx_t     = 0;
    int         rx_run   = 0;
    bit         rx_hi    = 1'b0;
    logic [9:0] rx_raw   = '0;
    logic [7:0] rx_q [$];
    logic [9:0] raw_q [$];
    int         run_q [$];
    int         done_count = 0;

    logic [7:0] exp_q [$];

    assign reg_data = regs[reg_addr];

    reg_dump_tx #(
        .CLKS_PER_BIT (CPB),
        .HEADER_BYTE  (8'hA5)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .dump_req (dump_req),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .cpu_halt (cpu_halt),
        .busy     (busy),
        .done     (done),
        .tx       (tx)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // UART receiver: samples each bit in its middle, records data byte,
    // raw 10-bit frame and the length of the initial low run.
    initial begin
        forever begin
            @(negedge clock);
            if (done === 1'b1) done_count++;
            if (rx_flush) begin
                rx_on = 1'b0;
            end else if (!rx_on) begin
                if (tx === 1'b0) begin
                    rx_on  = 1'b1;
                    rx_t   = 0;
                    rx_run = 1;
                    rx_hi  = 1'b0;
                    rx_raw = '0;
                end
            end else begin
                rx_t++;
                if (!rx_hi) begin
                    if (tx === 1'b0) rx_run++;
                    else rx_hi = 1'b1;
                end
                if (rx_t % CPB == CPB / 2) rx_raw[rx_t / CPB] = tx;
                if (rx_t == 9 * CPB + CPB / 2) begin
                    rx_q.push_back(rx_raw[8:1]);
                    raw_q.push_back(rx_raw);
                    run_q.push_back(rx_run);
                    rx_on = 1'b0;
                end
            end
        end
    end

    // ---------------- helpers (no comparisons) ----------------
    task automatic build_expected;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int r = 0; r < 32; r++)
            for (int b = 3; b >= 0; b--)
                exp_q.push_back(8'((regs[r] >> (8 * b)) & 32'hFF));
    endtask

    task automatic randomize_regs;
        for (int r = 0; r < 32; r++) regs[r] = $urandom;
    endtask

    task automatic flush_rx;
        rx_flush = 1'b1;
        repeat (2) @(negedge clock);
        rx_q.delete();
        raw_q.delete();
        run_q.delete();
        rx_flush = 1'b0;
    endtask

    task automatic start_dump;
        @(negedge clock);
        dump_req = 1'b1;
        @(negedge clock);
        dump_req = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int halt_low, output bit to);
        lat = 0; halt_low = 0; to = 1'b1;
        for (int i = 0; i < DUMP_CYCLES + 500; i++) begin
            @(negedge clock);
            lat++;
            if (done === 1'b1) begin
                to = 1'b0;
                break;
            end
            if (cpu_halt !== 1'b1) halt_low++;
        end
    endtask

    task automatic wait_rx(input int n, output bit to);
        to = 1'b1;
        for (int i = 0; i < DUMP_CYCLES + 500; i++) begin
            @(negedge clock);
            if (rx_q.size() >= n) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        int ndone;
        reset = 1'b1;
        dump_req = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b exp 1", tx); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
        n_checks++; if (cpu_halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %b exp 0", cpu_halt); end
        n_checks++; if (reg_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %0d exp 0", reg_addr); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", done); end
        ndone = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (done !== 1'b0 || tx !== 1'b1) ndone++;
        end
        n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL reset_quiet: got %0d active cycles exp 0", ndone); end
    endtask

    task automatic test_full_dump;
        int lat, hl, d0, nbad, first;
        bit to;
        int seq [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        logic [9:0] hdr_exp;
        for (int r = 0; r < 32; r++) regs[r] = 32'h01020300 + r;
        regs[29] = 32'h0000_7FFC;
        build_expected();
        flush_rx();
        d0 = done_count;
        start_dump();
        n_checks++; if (busy !== 1'b1 || cpu_halt !== 1'b1) begin
            n_fail++; $display("FAIL full_accept: got busy=%b halt=%b exp 1/1", busy, cpu_halt); end
        wait_done(lat, hl, to);
        n_checks++; if (to || lat !== DUMP_CYCLES) begin
            n_fail++; $display("FAIL full_latency: got %0d (timeout=%0d) exp %0d", lat, to, DUMP_CYCLES); end
        n_checks++; if (hl !== 0) begin n_fail++; $display("FAIL full_halt: got %0d low cycles exp 0", hl); end
        repeat (10) @(negedge clock);
        n_checks++; if (done_count - d0 !== 1) begin
            n_fail++; $display("FAIL full_done_count: got %0d exp 1", done_count - d0); end
        nbad = 0; first = -1;
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            if (rx_q[i] !== exp_q[i]) begin nbad++; if (first < 0) first = i; end
        n_checks++; if (rx_q.size() !== FRAME_LEN || nbad !== 0) begin
            n_fail++; $display("FAIL full_frame: got %0d bytes, %0d wrong (first at %0d) exp %0d bytes, 0 wrong",
                               rx_q.size(), nbad, first, FRAME_LEN); end
        for (int k = 0; k < 10; k++) hdr_exp[k] = seq[k][0];
        if (raw_q.size() > 0) begin
            n_checks++; if (run_q[0] !== CPB) begin
                n_fail++; $display("FAIL start_bit_len: got %0d exp %0d", run_q[0], CPB); end
            n_checks++; if (raw_q[0] !== hdr_exp) begin
                n_fail++; $display("FAIL header_bits: got %b exp %b", raw_q[0], hdr_exp); end
        end else begin
            n_checks++; n_fail++; $display("FAIL header_bits: got no byte exp one");
        end
    endtask

    task automatic test_ignored_request;
        int lat, hl, d0, nbad;
        bit to, to2;
        randomize_regs();
        build_expected();
        flush_rx();
        d0 = done_count;
        start_dump();
        wait_rx(50, to);
        @(negedge clock); dump_req = 1'b1;
        @(negedge clock); dump_req = 1'b0;
        wait_done(lat, hl, to2);
        repeat (20) @(negedge clock);
        n_checks++; if (to || to2 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ignored_idle: got busy=%b timeout=%0d/%0d exp busy 0", busy, to, to2); end
        n_checks++; if (done_count - d0 !== 1) begin
            n_fail++; $display("FAIL ignored_done_count: got %0d exp 1", done_count - d0); end
        nbad = 0;
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) if (rx_q[i] !== exp_q[i]) nbad++;
        n_checks++; if (rx_q.size() !== FRAME_LEN || nbad !== 0) begin
            n_fail++; $display("FAIL ignored_frame: got %0d bytes, %0d wrong exp %0d, 0", rx_q.size(), nbad, FRAME_LEN); end
    endtask

    task automatic test_back_to_back;
        int lat, hl, nbad;
        bit to;
        randomize_regs();
        build_expected();
        flush_rx();
        @(negedge clock); dump_req = 1'b1;
        @(negedge clock);
        wait_done(lat, hl, to);
        n_checks++; if (to || lat !== DUMP_CYCLES) begin
            n_fail++; $display("FAIL b2b_latency1: got %0d exp %0d", lat, DUMP_CYCLES); end
        nbad = 0;
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) if (rx_q[i] !== exp_q[i]) nbad++;
        n_checks++; if (rx_q.size() !== FRAME_LEN || nbad !== 0) begin
            n_fail++; $display("FAIL b2b_frame1: got %0d bytes, %0d wrong exp %0d, 0", rx_q.size(), nbad, FRAME_LEN); end
        rx_q.delete(); raw_q.delete(); run_q.delete();
        randomize_regs();
        build_expected();
        @(negedge clock);
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL b2b_restart: got busy=%b done=%b exp 1/0", busy, done); end
        dump_req = 1'b0;
        wait_done(lat, hl, to);
        n_checks++; if (to || lat !== DUMP_CYCLES || hl !== 0) begin
            n_fail++; $display("FAIL b2b_latency2: got %0d halt_low=%0d exp %0d, 0", lat, hl, DUMP_CYCLES); end
        nbad = 0;
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) if (rx_q[i] !== exp_q[i]) nbad++;
        n_checks++; if (rx_q.size() !== FRAME_LEN || nbad !== 0) begin
            n_fail++; $display("FAIL b2b_frame2: got %0d bytes, %0d wrong exp %0d, 0", rx_q.size(), nbad, FRAME_LEN); end
    endtask

    task automatic test_reset_mid_dump;
        int lat, hl, d0, nbad;
        bit to, hit;
        randomize_regs();
        flush_rx();
        start_dump();
        wait_rx(70, to);
        hit = 1'b0;
        for (int i = 0; i < 100 && !to; i++) begin
            @(negedge clock);
            if (rx_on && rx_t == 2 * CPB + 1) begin hit = 1'b1; break; end
        end
        n_checks++; if (!hit) begin n_fail++; $display("FAIL midreset_reach: got no bit 2 of byte 70 exp reached"); end
        reset = 1'b1;
        @(negedge clock);
        n_checks++; if (tx !== 1'b1 || busy !== 1'b0 || cpu_halt !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs: got tx=%b busy=%b halt=%b exp 1/0/0", tx, busy, cpu_halt); end
        n_checks++; if (reg_addr !== 5'd0) begin
            n_fail++; $display("FAIL midreset_addr: got %0d exp 0", reg_addr); end
        reset = 1'b0;
        flush_rx();
        randomize_regs();
        build_expected();
        d0 = done_count;
        start_dump();
        wait_done(lat, hl, to);
        n_checks++; if (to || lat !== DUMP_CYCLES) begin
            n_fail++; $display("FAIL midreset_latency: got %0d exp %0d", lat, DUMP_CYCLES); end
        repeat (10) @(negedge clock);
        n_checks++; if (done_count - d0 !== 1) begin
            n_fail++; $display("FAIL midreset_done_count: got %0d exp 1", done_count - d0); end
        nbad = 0;
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) if (rx_q[i] !== exp_q[i]) nbad++;
        n_checks++; if (rx_q.size() !== FRAME_LEN || nbad !== 0) begin
            n_fail++; $display("FAIL midreset_frame: got %0d bytes, %0d wrong exp %0d, 0", rx_q.size(), nbad, FRAME_LEN); end
    endtask

    task automatic test_changing_regs;
        int lat, hl, nbad;
        bit to, to2;
        randomize_regs();
        build_expected();
        flush_rx();
        start_dump();
        // Header + r0..r4 + first byte of r5 received: r5 already latched.
        wait_rx(22, to);
        n_checks++; if (to || reg_addr !== 5'd5) begin
            n_fail++; $display("FAIL change_addr: got %0d exp 5", reg_addr); end
        regs[5] = ~regs[5];
        wait_done(lat, hl, to2);
        nbad = 0;
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) if (rx_q[i] !== exp_q[i]) nbad++;
        n_checks++; if (to2 || rx_q.size() !== FRAME_LEN || nbad !== 0) begin
            n_fail++; $display("FAIL change_frame: got %0d bytes, %0d wrong exp %0d, 0", rx_q.size(), nbad, FRAME_LEN); end
    endtask

    initial begin
        reset = 1'b1;
        dump_req = 1'b0;
        for (int r = 0; r < 32; r++) regs[r] = '0;
        test_reset();
        test_full_dump();
        test_ignored_request();
        test_back_to_back();
        test_reset_mid_dump();
        test_changing_regs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
